// File: rtl/pc_gen.sv
// Next-PC generator: architectural PC, branch/jump/jr redirect, exceptions, eret, optional delay slot.
// Optional performance counters are built only when PC_GEN_PERF_EN is defined.
module pc_gen #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int unsigned DELAY_SLOT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [31:0]       ins,
    input  logic              if_beq,
    input  logic              if_bne,
    input  logic              zero,
    input  logic              if_j,
    input  logic              if_jr,
    input  logic [ADDR_W-1:0] bushA,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic [ADDR_W-1:0] jal_pc,
    output logic [ADDR_W-1:0] epc,
    output logic              in_slot,
    output logic              sel_err,
    output logic [31:0]       taken_cnt,
    output logic [31:0]       exc_cnt
);

    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] EXC_PC  = ADDR_W'(EXC_VECTOR);
    localparam logic [ADDR_W-1:0] LINK_OF = ADDR_W'((DELAY_SLOT != 0) ? 8 : 4);

    typedef enum logic {IDLE = 1'b0, SLOT = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pending;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] ctl_tgt;
    logic              br_taken;
    logic              in_slot_now;
    logic              taken;
    logic              mis_jr;
    logic              exc;

    logic unused_ins;
    assign unused_ins = &{1'b0, ins[31:26]};

    // Target selection, exception detection and next-PC prediction
    always_comb begin
        pc4         = pc + ADDR_W'(4);
        br_off      = {{(ADDR_W-18){ins[15]}}, ins[15:0], 2'b00};
        br_tgt      = pc4 + br_off;
        j_tgt       = pc4;
        j_tgt[27:0] = {ins[25:0], 2'b00};
        br_taken    = (if_beq & zero) | (if_bne & ~zero);
        in_slot_now = (DELAY_SLOT != 0) && (state == SLOT);

        if (if_jr)     ctl_tgt = bushA;
        else if (if_j) ctl_tgt = j_tgt;
        else           ctl_tgt = br_tgt;

        // Control instructions sitting in a delay slot are ignored
        taken   = (br_taken | if_j | if_jr) & ~in_slot_now;
        mis_jr  = if_jr & (bushA[1:0] != 2'b00) & ~in_slot_now;
        exc     = exc_req | mis_jr;
        sel_err = (br_taken & if_j) | (br_taken & if_jr) | (if_j & if_jr)
                | (in_slot_now & (if_beq | if_bne | if_j | if_jr));

        if (exc)                 npc = EXC_PC;
        else if (eret)           npc = epc;
        else if (in_slot_now)    npc = pending;
        else if (DELAY_SLOT != 0) npc = pc4;
        else if (taken)          npc = ctl_tgt;
        else                     npc = pc4;
    end

    assign jal_pc = pc + LINK_OF;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RST_PC;
            epc     <= '0;
            in_slot <= 1'b0;
            pending <= '0;
            state   <= IDLE;
        end else if (exc) begin
            pc      <= EXC_PC;
            epc     <= in_slot ? (pc - ADDR_W'(4)) : pc;
            in_slot <= 1'b0;
            pending <= '0;
            state   <= IDLE;
        end else if (eret) begin
            pc      <= epc;
            in_slot <= 1'b0;
            state   <= IDLE;
        end else if (!stall) begin
            pc <= npc;
            if (in_slot_now) begin
                state   <= IDLE;
                in_slot <= 1'b0;
            end else if ((DELAY_SLOT != 0) && taken) begin
                pending <= ctl_tgt;
                state   <= SLOT;
                in_slot <= 1'b1;
            end
        end
    end

`ifdef PC_GEN_PERF_EN
    logic [31:0] taken_q;
    logic [31:0] exc_q;

    // Redirects count once, on the edge that latches them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q <= '0;
            exc_q   <= '0;
        end else begin
            if (exc)
                exc_q <= exc_q + 32'd1;
            else if (!eret && !stall && taken)
                taken_q <= taken_q + 32'd1;
        end
    end

    assign taken_cnt = taken_q;
    assign exc_cnt   = exc_q;
`else
    assign taken_cnt = '0;
    assign exc_cnt   = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: one instance without and one with a delay slot.
module tb_pc_gen;

`ifdef PC_GEN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n0, rst_n1;
    logic        stall, if_beq, if_bne, zero, if_j, if_jr, exc_req, eret;
    logic [31:0] ins, bushA;

    logic [31:0] pc0, npc0, jal0, epc0, tc0, ec0;
    logic [31:0] pc1, npc1, jal1, epc1, tc1, ec1;
    logic        slot0, serr0, slot1, serr1;

    int errors = 0;
    int checks = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    always #5 clk = ~clk;

    pc_gen #(.DELAY_SLOT(0)) dut0 (
        .clk(clk), .rst_n(rst_n0), .stall(stall), .ins(ins),
        .if_beq(if_beq), .if_bne(if_bne), .zero(zero), .if_j(if_j), .if_jr(if_jr),
        .bushA(bushA), .exc_req(exc_req), .eret(eret),
        .pc(pc0), .npc(npc0), .jal_pc(jal0), .epc(epc0), .in_slot(slot0),
        .sel_err(serr0), .taken_cnt(tc0), .exc_cnt(ec0)
    );

    pc_gen #(.DELAY_SLOT(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .stall(stall), .ins(ins),
        .if_beq(if_beq), .if_bne(if_bne), .zero(zero), .if_j(if_j), .if_jr(if_jr),
        .bushA(bushA), .exc_req(exc_req), .eret(eret),
        .pc(pc1), .npc(npc1), .jal_pc(jal1), .epc(epc1), .in_slot(slot1),
        .sel_err(serr1), .taken_cnt(tc1), .exc_cnt(ec1)
    );

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        checks++;
        if (val_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h", obs);
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            assert (obs === v) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", t, obs, v);
            end
        end
    endtask

    task automatic idle();
        if_beq = 1'b0; if_bne = 1'b0; zero = 1'b0; if_j = 1'b0; if_jr = 1'b0;
        exc_req = 1'b0; eret = 1'b0; ins = 32'h0; bushA = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        stall = 1'b0; rst_n0 = 1'b0; rst_n1 = 1'b0;

        // ---------------- no delay slot ----------------
        tick(); tick();
        push("rst_pc", 32'h3000);   check(pc0);
        push("rst_epc", 32'h0);     check(epc0);
        push("rst_slot", 32'h0);    check(32'(slot0));
        push("rst_tcnt", 32'h0);    check(tc0);
        rst_n0 = 1'b1;
        tick(); push("seq1", 32'h3004); check(pc0);
        tick(); push("seq2", 32'h3008); check(pc0);
        tick(); tick();
        push("pre_beq", 32'h3010); check(pc0);

        if_beq = 1'b1; zero = 1'b1; ins = 32'h1000_FFFC; #1;
        push("beq_npc", 32'h3004); check(npc0);
        push("beq_jal", 32'h3014); check(jal0);
        push("beq_serr", 32'h0);   check(32'(serr0));
        tick(); push("beq_pc", 32'h3004); check(pc0);

        idle(); tick(); tick(); tick();
        if_beq = 1'b1; zero = 1'b0; ins = 32'h1000_FFFC;
        tick(); push("beq_nt_pc", 32'h3014); check(pc0);

        idle(); if_j = 1'b1; ins = 32'h0800_0C40;
        tick(); push("j_pc", 32'h3100); check(pc0);

        idle(); if_j = 1'b1; if_jr = 1'b1; ins = 32'h0800_0C40; bushA = 32'h3200; #1;
        push("pri_npc", 32'h3200); check(npc0);
        push("pri_serr", 32'h1);   check(32'(serr0));
        tick(); push("jr_pc", 32'h3200); check(pc0);

        idle(); if_jr = 1'b1; bushA = 32'h3202; #1;
        push("misjr_npc", 32'h4180); check(npc0);
        tick();
        push("misjr_pc", 32'h4180);  check(pc0);
        push("misjr_epc", 32'h3200); check(epc0);
        push("misjr_ecnt", PERF ? 32'd1 : 32'd0); check(ec0);

        idle(); eret = 1'b1; #1;
        push("eret_npc", 32'h3200); check(npc0);
        tick(); push("eret_pc", 32'h3200); check(pc0);

        idle(); if_bne = 1'b1; zero = 1'b0; ins = 32'h1400_0004;
        tick(); push("bne_pc", 32'h3214); check(pc0);
        idle(); if_beq = 1'b1; zero = 1'b1; ins = 32'h1000_0000;
        tick(); push("beq0_pc", 32'h3218); check(pc0);
        idle();
        push("tcnt5", PERF ? 32'd5 : 32'd0); check(tc0);

        // ---------------- one delay slot ----------------
        rst_n0 = 1'b0;
        tick(); tick();
        push("ds_rst_pc", 32'h3000); check(pc1);
        rst_n1 = 1'b1;

        if_j = 1'b1; ins = 32'h0800_0C40; #1;
        push("ds_j_npc", 32'h3004); check(npc1);
        push("ds_jal", 32'h3008);   check(jal1);
        tick();
        push("ds_slot_pc", 32'h3004); check(pc1);
        push("ds_in_slot", 32'h1);    check(32'(slot1));

        idle(); stall = 1'b1; #1;
        push("ds_stall_npc", 32'h3100); check(npc1);
        tick(); tick(); tick();
        push("ds_stall_pc", 32'h3004); check(pc1);
        push("ds_stall_slot", 32'h1);  check(32'(slot1));

        stall = 1'b0; if_j = 1'b1; ins = 32'h0800_0C00; #1;
        push("ds_slot_serr", 32'h1); check(32'(serr1));
        tick();
        push("ds_redir_pc", 32'h3100); check(pc1);
        push("ds_redir_slot", 32'h0);  check(32'(slot1));
        idle();
        push("ds_jal2", 32'h3108);     check(jal1);

        rst_n1 = 1'b0; exc_req = 1'b1; eret = 1'b1; stall = 1'b1;
        tick();
        push("rst_ovr_pc", 32'h3000); check(pc1);
        push("rst_ovr_epc", 32'h0);   check(epc1);
        idle(); stall = 1'b0; rst_n1 = 1'b1;

        if_j = 1'b1; ins = 32'h0800_0C40;
        tick(); push("ds2_slot_pc", 32'h3004); check(pc1);

        idle(); exc_req = 1'b1; stall = 1'b1; #1;
        push("slot_exc_npc", 32'h4180); check(npc1);
        tick();
        push("slot_exc_pc", 32'h4180);  check(pc1);
        push("slot_exc_epc", 32'h3000); check(epc1);
        push("slot_exc_slot", 32'h0);   check(32'(slot1));
        push("ds_ecnt", PERF ? 32'd1 : 32'd0); check(ec1);
        push("ds_tcnt", PERF ? 32'd1 : 32'd0); check(tc1);

        idle(); stall = 1'b0; eret = 1'b1;
        tick(); push("ds_eret_pc", 32'h3000); check(pc1);
        idle();
        tick(); push("ds_after_eret", 32'h3004); check(pc1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
